// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard controller for the 5-stage pipeline.  It
// sits beside the ID/EX pipeline register and keeps a shadow scoreboard of
// the instructions that currently occupy EX and MEM.  It produces:
//   * registered 2-bit select codes for the two ALU operand forwarding muxes
//     (00 = register file, 10 = EX/MEM, 01 = MEM/WB; 11 is never driven),
//   * a combinational ID-stage stall and ID/EX bubble for load-use hazards.
//
// Ports
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   start_i                   leaves IDLE (level, sampled every cycle)
//   id_valid_i                ID stage holds a real instruction
//   id_rs1_i, id_rs2_i        ID source registers
//   id_use_rs1_i/id_use_rs2_i instruction really reads rs1 / rs2
//   id_rd_i, id_regwrite_i    ID destination register and write enable
//   id_memread_i              ID instruction is a load
//   flush_i                   ID instruction is killed this cycle
//   forward_a_o, forward_b_o  forwarding mux selects for EX operands A / B
//   stall_o, bubble_o         hold PC + IF/ID, insert NOP into ID/EX
//   stall_cnt_o               number of cycles with stall_o = 1
//
// Build option
//   FWD_STALL_CNT_EN  when defined, stall_cnt_o is a saturating counter of
//                     stall cycles cleared only by rst_i; otherwise the
//                     counter is absent and stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic [31:0]           stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL
    } state_t;

    state_t state;

    // Scoreboard slots.  The WB stage needs no flops here: the write-first
    // register file already resolves WB-to-ID reads, so nothing in this
    // block would ever consult a WB slot.  Likewise only EX needs memread,
    // because a load-use hazard is only visible one slot ahead of ID.
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_regwrite;

    logic ex_hit_rs1;
    logic ex_hit_rs2;
    logic mem_hit_rs1;
    logic mem_hit_rs2;
    logic hazard;
    logic kill_id;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // A slot produces register r only if it is a real, writing instruction
    // with a non-zero destination equal to r; x0 therefore never matches.
    function automatic logic slot_match(
        input logic                  v,
        input logic                  rw,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] r
    );
        return v & rw & (rd != '0) & (rd == r);
    endfunction

    assign ex_hit_rs1  = id_use_rs1_i & slot_match(ex_valid,  ex_regwrite,  ex_rd,  id_rs1_i);
    assign ex_hit_rs2  = id_use_rs2_i & slot_match(ex_valid,  ex_regwrite,  ex_rd,  id_rs2_i);
    assign mem_hit_rs1 = id_use_rs1_i & slot_match(mem_valid, mem_regwrite, mem_rd, id_rs1_i);
    assign mem_hit_rs2 = id_use_rs2_i & slot_match(mem_valid, mem_regwrite, mem_rd, id_rs2_i);

    // Load-use: the consumer in ID needs a value that the load in EX only
    // has after MEM.  A flushed ID instruction never stalls.
    assign hazard   = (state != ST_IDLE) & id_valid_i & ~flush_i & ex_memread
                    & (ex_hit_rs1 | ex_hit_rs2);
    assign stall_o  = hazard;
    assign bubble_o = hazard;

    // Nearest producer (EX) wins over the older one (MEM).
    assign fwd_a_next = ex_hit_rs1 ? 2'b10 : (mem_hit_rs1 ? 2'b01 : 2'b00);
    assign fwd_b_next = ex_hit_rs2 ? 2'b10 : (mem_hit_rs2 ? 2'b01 : 2'b00);

    // Nothing real enters EX when ID is empty, flushed or held back.
    assign kill_id = ~id_valid_i | flush_i | hazard;

    // Control FSM, scoreboard shift and registered forwarding selects.  In
    // IDLE the scoreboard is kept empty so the first instruction after start
    // can never forward stale data.  A stall always puts a bubble into EX,
    // which is why STALL can return to RUN without re-checking the hazard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            forward_a_o  <= 2'b00;
            forward_b_o  <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    ex_valid    <= 1'b0;
                    mem_valid   <= 1'b0;
                    forward_a_o <= 2'b00;
                    forward_b_o <= 2'b00;
                    if (start_i) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    ex_valid     <= ~kill_id;
                    ex_rd        <= id_rd_i;
                    ex_regwrite  <= id_regwrite_i;
                    ex_memread   <= id_memread_i;
                    mem_valid    <= ex_valid;
                    mem_rd       <= ex_rd;
                    mem_regwrite <= ex_regwrite;
                    forward_a_o  <= kill_id ? 2'b00 : fwd_a_next;
                    forward_b_o  <= kill_id ? 2'b00 : fwd_b_next;
                    if ((state == ST_RUN) && hazard) begin
                        state <= ST_STALL;
                    end else begin
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating stall-cycle counter; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
